// File: rtl/fpna_cfg_loader.sv
// rtl/fpna_cfg_loader.sv - serial config loader for the neuron fabric; optional parity check via CFG_PARITY_EN
module fpna_cfg_loader #(
   parameter int NUM_CELLS = 10,
   parameter int CELL_BITS = 8
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           config_en,
   input  logic                           bs_in,
   output logic                           bs_out,
   output logic [NUM_CELLS*CELL_BITS-1:0] cfg_word,
   output logic                           cfg_load,
   output logic                           cfg_busy,
   output logic                           cfg_done,
   output logic                           cfg_err
);

   localparam int TOTAL = NUM_CELLS * CELL_BITS;
   localparam int CW    = $clog2(TOTAL + 2);
   localparam logic [CW-1:0] CNT_MAX = CW'(TOTAL + 1);
`ifdef CFG_PARITY_EN
   localparam logic [CW-1:0] EXP = CW'(TOTAL + 1);
`else
   localparam logic [CW-1:0] EXP = CW'(TOTAL);
`endif

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_CHECK, S_LOAD} state_t;

   state_t            state, next_state;
   logic [TOTAL-1:0]  shadow;
   logic [CW-1:0]     count;
   logic              start;
   logic              shift_en;
   logic              commit_ok;

   assign start    = config_en && (state == S_IDLE);
   assign shift_en = config_en && ((state == S_IDLE) || (state == S_SHIFT));

`ifdef CFG_PARITY_EN
   logic par_acc;
   logic par_slot;

   // The bit arriving while count==TOTAL is the parity bit; it never enters the shadow.
   assign par_slot  = (state == S_SHIFT) && (count == CW'(TOTAL));
   assign commit_ok = (count == EXP) && !par_acc;

   // Even-parity accumulator over every bit of the session.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par_acc <= 1'b0;
      end else if (start) begin
         par_acc <= bs_in;
      end else if (shift_en) begin
         par_acc <= par_acc ^ bs_in;
      end
   end
`else
   logic par_slot;

   assign par_slot  = 1'b0;
   assign commit_ok = (count == EXP);
`endif

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state decode; config_en only matters in IDLE and SHIFT.
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:  if (config_en) next_state = S_SHIFT;
         S_SHIFT: if (!config_en) next_state = S_CHECK;
         S_CHECK: next_state = commit_ok ? S_LOAD : S_IDLE;
         S_LOAD:  next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   // Registered status strobes decoded from the upcoming state, so they align with it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cfg_load <= 1'b0;
         cfg_busy <= 1'b0;
      end else begin
         cfg_load <= (next_state == S_LOAD);
         cfg_busy <= (next_state != S_IDLE);
      end
   end

   // Shadow chain, daisy-chain output and saturating bit counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow <= '0;
         bs_out <= 1'b0;
         count  <= '0;
      end else if (shift_en) begin
         if (start) begin
            count <= CW'(1);
         end else if (count != CNT_MAX) begin
            count <= count + CW'(1);
         end
         if (!par_slot) begin
            shadow <= {shadow[TOTAL-2:0], bs_in};
            bs_out <= shadow[TOTAL-1];
         end
      end
   end

   // Active configuration and sticky done/error flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cfg_word <= '0;
         cfg_done <= 1'b0;
         cfg_err  <= 1'b0;
      end else begin
         if (start) begin
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
         end
         if (state == S_CHECK) begin
            if (commit_ok) begin
               cfg_word <= shadow;
            end else begin
               cfg_err <= 1'b1;
            end
         end
         if (state == S_LOAD) begin
            cfg_done <= 1'b1;
         end
      end
   end

endmodule
